ahblite_slave_mux_ng: RTL and testbench

//  - Parametrised AHB-Lite data-phase response mux for NPORT slaves; successor to the fixed 5-port mux.
//  - Registers the one-hot HSEL at each accepted address phase and steers the selected slave's HREADYOUT/HRESP/HRDATA to the master.
//  - Adds a built-in default slave: any active transfer (NONSEQ/SEQ) with no HSEL, or more than one HSEL, gets a two-cycle ERROR response.
//  - Sits between the address decoder and the Cortex-M0 master; its HREADYOUT is fed back as the bus-level HREADY.

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/ahb_default_slave.sv | 76 +++++++
 rtl/ahblite_slave_mux_ng.sv | 184 ++++++++++++++++++
 tb/tb_ahblite_slave_mux_ng.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the slave response mux and its default
// slave: HTRANS encodings, HRESP encodings, the default-slave state type and
// a small helper that says whether an HTRANS value starts a real transfer.
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default-slave response sequence: IDLE (not responding), then the two
    // cycles of an AHB ERROR response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } ds_state_t;

    // NONSEQ and SEQ are the only transfer types that need a slave response.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Built-in default slave for the AHB-Lite response mux. An active transfer
// whose HSEL is not one-hot receives the standard two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESET   bus clock, async active-high reset
//   HREADY         bus-level HREADY; addresses are only accepted when high
//   HTRANS         master address-phase transfer type
//   hsel_valid     1 when the decoder HSEL is exactly one-hot
//   ds_hreadyout   default-slave ready (low in the first ERROR cycle)
//   ds_hresp       default-slave response
//   ds_active      1 while the default slave owns the data phase
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       hsel_valid,
    output logic       ds_hreadyout,
    output logic       ds_hresp,
    output logic       ds_active
);

    ds_state_t state_q;
    ds_state_t state_d;
    ds_state_t capture_state;

    // State register; reset drops straight back to IDLE so no partial ERROR
    // cycle can leak out after a reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs. ERR1 always advances to ERR2 because the low
    // HREADYOUT in ERR1 is what stalls the bus; IDLE and ERR2 re-evaluate the
    // new address phase whenever HREADY allows it to be accepted.
    always_comb begin
        capture_state = (htrans_active(HTRANS) && !hsel_valid) ? ERR1 : IDLE;
        state_d       = state_q;
        ds_hreadyout  = 1'b1;
        ds_hresp      = HRESP_OKAY;
        ds_active     = 1'b0;
        case (state_q)
            IDLE: begin
                if (HREADY) begin
                    state_d = capture_state;
                end
            end
            ERR1: begin
                ds_hreadyout = 1'b0;
                ds_hresp     = HRESP_ERROR;
                ds_active    = 1'b1;
                state_d      = ERR2;
            end
            ERR2: begin
                ds_hresp  = HRESP_ERROR;
                ds_active = 1'b1;
                if (HREADY) begin
                    state_d = capture_state;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux_ng.sv
// ---------------------------------------------------------------------------
// ahblite_slave_mux_ng
// Parametrised AHB-Lite data-phase response mux for NPORT slaves with a
// built-in default slave. The one-hot HSEL is registered at each accepted
// address phase and the selected slave's HREADYOUT/HRESP/HRDATA are steered
// to the master. Transfers with no or multiple selects get an ERROR.
//
// Optional feature macro: AHB_SLVMUX_WDOG_EN
//   When defined, a saturating stall watchdog raises a sticky WDOG_FLAG and
//   records the stalling port in WDOG_PORT once a slave has held HREADYOUT
//   low for TIMEOUT+1 cycles. Bus responses are never altered by it.
//   When undefined, WDOG_FLAG/WDOG_PORT are tied 0 and WDOG_CLR is unused.
//
// Parameters: NPORT (1..16), DW (HRDATA width), TIMEOUT (watchdog limit)
// Ports:
//   HCLK, HRESET   bus clock, async active-high reset
//   HREADY         bus-level HREADY (this block's HREADYOUT fed back)
//   HTRANS         master HTRANS, address phase
//   HSEL           decoder selects, bit i = port i
//   HREADYOUT_S    per-slave HREADYOUT
//   HRESP_S        per-slave HRESP
//   HRDATA_S       per-slave HRDATA, port i at [i*DW +: DW]
//   HREADYOUT      muxed ready to the master
//   HRESP          muxed response
//   HRDATA         muxed read data
//   WDOG_FLAG      sticky stall-timeout flag
//   WDOG_PORT      index of the port that timed out
//   WDOG_CLR       clears WDOG_FLAG/WDOG_PORT
// ---------------------------------------------------------------------------
module ahblite_slave_mux_ng
    import ahb_pkg::*;
#(
    parameter int NPORT   = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HREADY,
    input  logic [1:0]          HTRANS,
    input  logic [NPORT-1:0]    HSEL,
    input  logic [NPORT-1:0]    HREADYOUT_S,
    input  logic [NPORT-1:0]    HRESP_S,
    input  logic [NPORT*DW-1:0] HRDATA_S,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [DW-1:0]       HRDATA,
    output logic                WDOG_FLAG,
    output logic [3:0]          WDOG_PORT,
    input  logic                WDOG_CLR
);

    localparam logic [NPORT-1:0] ONE = NPORT'(1);

    logic [NPORT-1:0] sel_q;
    logic             hsel_onehot;
    logic             ds_hreadyout;
    logic             ds_hresp;
    logic             ds_active;
    logic             mux_ready;
    logic             mux_resp;
    logic [DW-1:0]    mux_data;
    logic [DW-1:0]    data_term [NPORT];

    // x & (x-1) clears the lowest set bit, so a non-zero value that becomes
    // zero had exactly one bit set.
    assign hsel_onehot = (HSEL != '0) && ((HSEL & (HSEL - ONE)) == '0);

    // Data-phase select. Only a clean one-hot select is kept; anything else
    // is stored as zero so the slave mux outputs nothing while the default
    // slave (or the idle response) owns the data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= '0;
        end else if (HREADY) begin
            sel_q <= hsel_onehot ? HSEL : '0;
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HREADY       (HREADY),
        .HTRANS       (HTRANS),
        .hsel_valid   (hsel_onehot),
        .ds_hreadyout (ds_hreadyout),
        .ds_hresp     (ds_hresp),
        .ds_active    (ds_active)
    );

    // AND-OR mux: each port's data is masked by its select bit, so with a
    // one-hot sel_q the OR of all terms is the selected port's data.
    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_mux
            assign data_term[gi] = HRDATA_S[gi*DW +: DW] & {DW{sel_q[gi]}};
        end
    endgenerate

    always_comb begin
        mux_data = '0;
        for (int p = 0; p < NPORT; p++) begin
            mux_data = mux_data | data_term[p];
        end
    end

    assign mux_ready = |(sel_q & HREADYOUT_S);
    assign mux_resp  = |(sel_q & HRESP_S);

    // Final response to the master: default slave first, then the selected
    // slave, otherwise a zero-wait OKAY for idle/busy or unselected phases.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        if (ds_active) begin
            HREADYOUT = ds_hreadyout;
            HRESP     = ds_hresp;
        end else if (sel_q != '0) begin
            HREADYOUT = mux_ready;
            HRESP     = mux_resp;
            HRDATA    = mux_data;
        end
    end

`ifdef AHB_SLVMUX_WDOG_EN
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    logic [CW-1:0] stall_cnt;
    logic [3:0]    sel_idx;
    logic          stalled;
    logic          wdog_flag_q;
    logic [3:0]    wdog_port_q;

    assign stalled = (sel_q != '0) && !mux_ready;

    // Binary index of the selected port, recorded when the watchdog fires.
    always_comb begin
        sel_idx = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (sel_q[p]) begin
                sel_idx = 4'(p);
            end
        end
    end

    // Consecutive stall cycles of the selected slave, saturating at TIMEOUT.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            stall_cnt <= '0;
        end else if (!stalled) begin
            stall_cnt <= '0;
        end else if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    // Sticky flag; a set on the same edge as a clear takes priority so a
    // still-stalled slave cannot be silently cleared.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wdog_flag_q <= 1'b0;
            wdog_port_q <= '0;
        end else if (stall_cnt == CNT_MAX) begin
            wdog_flag_q <= 1'b1;
            wdog_port_q <= sel_idx;
        end else if (WDOG_CLR) begin
            wdog_flag_q <= 1'b0;
            wdog_port_q <= '0;
        end
    end

    assign WDOG_FLAG = wdog_flag_q;
    assign WDOG_PORT = wdog_port_q;
`else
    logic unused_wdog;

    assign WDOG_FLAG   = 1'b0;
    assign WDOG_PORT   = '0;
    assign unused_wdog = WDOG_CLR ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_ahblite_slave_mux_ng.sv
// ---------------------------------------------------------------------------
// tb_ahblite_slave_mux_ng
// Self-checking bench for ahblite_slave_mux_ng (NPORT=5, DW=32, TIMEOUT=8).
// A transaction-level model tracks who owns the current data phase (nobody,
// a slave port, or the default slave's ERROR cycle 1/2) plus a stall-run
// length for the watchdog, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ahblite_slave_mux_ng;

    localparam int NPORT   = 5;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

`ifdef AHB_SLVMUX_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic                HREADY;
    logic [1:0]          HTRANS;
    logic [NPORT-1:0]    HSEL;
    logic [NPORT-1:0]    HREADYOUT_S;
    logic [NPORT-1:0]    HRESP_S;
    logic [NPORT*DW-1:0] HRDATA_S;
    logic                HREADYOUT;
    logic                HRESP;
    logic [DW-1:0]       HRDATA;
    logic                WDOG_FLAG;
    logic [3:0]          WDOG_PORT;
    logic                WDOG_CLR;

    int tests_run  = 0;
    int fail_count = 0;

    // Reference model state
    int m_port;
    int m_err;
    int m_stall;
    bit m_flag;
    int m_flag_port;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahblite_slave_mux_ng #(
        .NPORT   (NPORT),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HREADY      (HREADY),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .WDOG_FLAG   (WDOG_FLAG),
        .WDOG_PORT   (WDOG_PORT),
        .WDOG_CLR    (WDOG_CLR)
    );

    function automatic logic [NPORT*DW-1:0] rand_data();
        logic [NPORT*DW-1:0] d;
        for (int p = 0; p < NPORT; p++) begin
            d[p*DW +: DW] = $urandom;
        end
        return d;
    endfunction

    task automatic model_reset();
        m_port      = -1;
        m_err       = 0;
        m_stall     = 0;
        m_flag      = 1'b0;
        m_flag_port = 0;
    endtask

    // Expected bus response from who owns the data phase right now.
    task automatic expected_bus(output logic e_ready, output logic e_resp,
                                output logic [DW-1:0] e_data);
        e_ready = 1'b1;
        e_resp  = 1'b0;
        e_data  = '0;
        if (m_err == 1) begin
            e_ready = 1'b0;
            e_resp  = 1'b1;
        end else if (m_err == 2) begin
            e_resp = 1'b1;
        end else if (m_port >= 0) begin
            e_ready = HREADYOUT_S[m_port];
            e_resp  = HRESP_S[m_port];
            e_data  = HRDATA_S[m_port*DW +: DW];
        end
    endtask

    // Advance the model across one clock edge using the inputs of this cycle.
    task automatic model_edge();
        logic          bus_ready;
        logic          r;
        logic [DW-1:0] d;
        int            ones;
        if (HRESET) begin
            model_reset();
            return;
        end
        expected_bus(bus_ready, r, d);
        if (WDOG_ON) begin
            if (m_stall >= TIMEOUT) begin
                m_flag      = 1'b1;
                m_flag_port = m_port;
            end else if (WDOG_CLR) begin
                m_flag      = 1'b0;
                m_flag_port = 0;
            end
            if (m_err == 0 && m_port >= 0 && !HREADYOUT_S[m_port]) m_stall++;
            else m_stall = 0;
        end
        if (m_err == 1) begin
            m_err = 2;
        end else if (bus_ready) begin
            ones = $countones(HSEL);
            if (ones == 1) begin
                m_err = 0;
                for (int p = 0; p < NPORT; p++) if (HSEL[p]) m_port = p;
            end else begin
                m_port = -1;
                m_err  = HTRANS[1] ? 1 : 0;
            end
        end
    endtask

    task automatic check_value(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge and let them settle.
    task automatic applyStimulus(input logic [1:0] t, input logic [NPORT-1:0] s,
                                 input logic [NPORT-1:0] rdy,
                                 input logic [NPORT-1:0] rsp, input logic clr,
                                 input logic [NPORT*DW-1:0] d);
        HTRANS      = t;
        HSEL        = s;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        WDOG_CLR    = clr;
        HRDATA_S    = d;
        #3;
    endtask

    task automatic checkOutput(input string tag);
        logic          e_ready;
        logic          e_resp;
        logic [DW-1:0] e_data;
        expected_bus(e_ready, e_resp, e_data);
        check_value({tag, "_hreadyout"}, DW'(HREADYOUT), DW'(e_ready));
        check_value({tag, "_hresp"},     DW'(HRESP),     DW'(e_resp));
        check_value({tag, "_hrdata"},    HRDATA,         e_data);
        check_value({tag, "_wdog_flag"}, DW'(WDOG_FLAG), DW'(m_flag));
        check_value({tag, "_wdog_port"}, DW'(WDOG_PORT), DW'(m_flag_port));
    endtask

    task automatic end_cycle();
        model_edge();
        @(posedge HCLK);
        #1;
    endtask

    task automatic run_cycle(input string tag, input logic [1:0] t,
                             input logic [NPORT-1:0] s, input logic [NPORT-1:0] rdy,
                             input logic clr);
        applyStimulus(t, s, rdy, '0, clr, rand_data());
        checkOutput(tag);
        end_cycle();
    endtask

    initial begin
        logic [NPORT*DW-1:0] d;
        logic [NPORT-1:0]    s;
        logic [NPORT-1:0]    rdy;
        logic [NPORT-1:0]    rsp;
        int                  sel_kind;
        int                  a;
        int                  b;

        // Reset state
        HRESET      = 1'b1;
        HTRANS      = T_IDLE;
        HSEL        = '0;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        HRDATA_S    = '0;
        WDOG_CLR    = 1'b0;
        model_reset();
        #2;
        checkOutput("reset");
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Slave 2 with three wait states, then read data
        run_cycle("t1_addr", T_NONSEQ, 5'b00100, '1, 1'b0);
        for (int k = 0; k < 3; k++) run_cycle("t1_wait", T_IDLE, '0, 5'b11011, 1'b0);
        d = rand_data();
        d[2*DW +: DW] = 32'hCAFEF00D;
        applyStimulus(T_IDLE, '0, '1, '0, 1'b0, d);
        checkOutput("t1_done");
        check_value("t1_data_const", HRDATA, 32'hCAFEF00D);
        end_cycle();

        // No select -> two-cycle ERROR
        run_cycle("t2_addr", T_NONSEQ, '0, '1, 1'b0);
        run_cycle("t2_err1", T_IDLE, '0, '1, 1'b0);
        run_cycle("t2_err2", T_IDLE, '0, '1, 1'b0);

        // Multi-hot select -> ERROR; idle with no select -> OKAY
        run_cycle("t3_addr", T_NONSEQ, 5'b00011, '1, 1'b0);
        run_cycle("t3_err1", T_IDLE, '0, '1, 1'b0);
        run_cycle("t3_err2", T_IDLE, 5'b00011, '1, 1'b0);
        run_cycle("t3_idle", T_IDLE, '0, '1, 1'b0);

        // Reset during ERR1
        run_cycle("t4_addr", T_NONSEQ, '0, '1, 1'b0);
        applyStimulus(T_IDLE, '0, '1, '0, 1'b0, rand_data());
        checkOutput("t4_err1");
        HRESET = 1'b1;
        #1;
        model_reset();
        checkOutput("t4_reset");
        end_cycle();
        HRESET = 1'b0;
        run_cycle("t4_addr0", T_NONSEQ, 5'b00001, '1, 1'b0);
        run_cycle("t4_data0", T_IDLE, '0, '1, 1'b0);

        // Port 3 stalls 20 cycles; watchdog fires after 9 stall cycles
        run_cycle("t5_addr", T_NONSEQ, 5'b01000, '1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(T_IDLE, '0, 5'b10111, '0, 1'b0, rand_data());
            checkOutput("t5_stall");
            if (k == 8) check_value("t5_flag_before", DW'(WDOG_FLAG), '0);
            if (k == 9) begin
                check_value("t5_flag_after", DW'(WDOG_FLAG), DW'(WDOG_ON));
                check_value("t5_port_after", DW'(WDOG_PORT), WDOG_ON ? 32'd3 : 32'd0);
            end
            end_cycle();
        end
        run_cycle("t5_done", T_IDLE, '0, '1, 1'b0);
        run_cycle("t5_clr", T_IDLE, '0, '1, 1'b1);
        applyStimulus(T_IDLE, '0, '1, '0, 1'b0, rand_data());
        checkOutput("t5_cleared");
        check_value("t5_flag_cleared", DW'(WDOG_FLAG), '0);
        end_cycle();

        // Randomised traffic, with one asynchronous reset in the middle
        for (int n = 0; n < 300; n++) begin
            sel_kind = $urandom_range(0, 9);
            if (sel_kind <= 5) begin
                s = NPORT'(1) << $urandom_range(0, NPORT - 1);
            end else if (sel_kind == 6) begin
                s = '0;
            end else if (sel_kind == 7) begin
                a = $urandom_range(0, NPORT - 1);
                b = (a + $urandom_range(1, NPORT - 1)) % NPORT;
                s = '0;
                s[a] = 1'b1;
                s[b] = 1'b1;
            end else begin
                s = NPORT'($urandom);
            end
            for (int p = 0; p < NPORT; p++) begin
                rdy[p] = ($urandom_range(0, 3) != 0);
                rsp[p] = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(2'($urandom_range(0, 3)), s, rdy, rsp,
                          ($urandom_range(0, 15) == 0), rand_data());
            checkOutput("rand");
            if (n == 150) begin
                HRESET = 1'b1;
                #1;
                model_reset();
                checkOutput("rand_reset");
                end_cycle();
                HRESET = 1'b0;
            end else begin
                end_cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
